// File: rtl/punc_mc_control_pkg.sv
// Shared encodings for the PUnC multi-cycle control unit: opcodes, FSM states
// and the select codes driven onto the datapath muxes.
package punc_defs;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RES  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_IND, ST_MEM, ST_WB, ST_PAUSE, ST_HALT
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_AND = 2'd1;
  localparam logic [1:0] ALU_NOT = 2'd2;

  localparam logic [1:0] PCSEL_INC   = 2'd0;
  localparam logic [1:0] PCSEL_OFF9  = 2'd1;
  localparam logic [1:0] PCSEL_BASER = 2'd2;
  localparam logic [1:0] PCSEL_OFF11 = 2'd3;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_MDR = 2'd1;
  localparam logic [1:0] WSEL_EA  = 2'd2;
  localparam logic [1:0] WSEL_PC  = 2'd3;

  localparam logic [1:0] ASEL_PC  = 2'd0;
  localparam logic [1:0] ASEL_EA  = 2'd1;
  localparam logic [1:0] ASEL_MDR = 2'd2;

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/punc_mem_wait.sv
// Memory completion detector: either follows mem_ready or counts a fixed
// number of wait cycles while an access is in progress.
module punc_mem_wait #(
  parameter int USE_MEM_READY = 1,
  parameter int MEM_LATENCY   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mem_ready,
  output logic done
);

  logic [3:0] cnt_reg;

  assign done = start && ((USE_MEM_READY != 0) ? mem_ready
                                               : (cnt_reg == 4'(MEM_LATENCY - 1)));

  // Cleared on completion so back-to-back accesses each get a full count.
  always_ff @(posedge clk) begin
    if (rst || !start || done)
      cnt_reg <= '0;
    else if (cnt_reg != 4'hF)
      cnt_reg <= cnt_reg + 4'd1;
  end

endmodule

// File: rtl/punc_mc_control.sv
// PUnC LC3 multi-cycle control FSM: sequences fetch/decode/execute/memory/
// writeback, with configurable memory wait, single-step debug and halt trap.
module punc_mc_control
  import punc_defs::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int MEM_LATENCY   = 1,
  parameter int DBG_SUPPORT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  input  logic        mem_ready,
  input  logic        dbg_en,
  input  logic        dbg_step,
  output logic        pc_ld,
  output logic [1:0]  pc_sel,
  output logic        ir_ld,
  output logic        mdr_ld,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic        rf_r7,
  output logic [1:0]  alu_op,
  output logic        cc_ld,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_asel,
  output logic        instr_done,
  output logic        paused,
  output logic        halted,
  output logic        illegal
);

  state_t     state_reg, state_next, retire_state;
  logic       illegal_reg;
  logic       mem_state, mem_done;
  logic [3:0] op;
  logic       ir_unused;

  assign op        = ir[15:12];
  assign ir_unused = ^ir[8:0];
  assign mem_state = (state_reg == ST_FETCH) || (state_reg == ST_IND) || (state_reg == ST_MEM);
  assign retire_state = ((DBG_SUPPORT != 0) && dbg_en) ? ST_PAUSE : ST_FETCH;
  assign illegal   = illegal_reg && !rst;

  punc_mem_wait #(
    .USE_MEM_READY(USE_MEM_READY),
    .MEM_LATENCY  (MEM_LATENCY)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .start    (mem_state),
    .mem_ready(mem_ready),
    .done     (mem_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DECODE && (op == OP_RTI || op == OP_RES))
        illegal_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH:  if (mem_done) state_next = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_TRAP, OP_RTI, OP_RES:     state_next = ST_HALT;
          OP_LD, OP_LDR, OP_ST, OP_STR: state_next = ST_MEM;
          OP_LDI, OP_STI:              state_next = ST_IND;
          default:                     state_next = ST_EXEC;
        endcase
      end
      ST_EXEC, ST_WB: state_next = retire_state;
      ST_IND:    if (mem_done) state_next = ST_MEM;
      ST_MEM:    if (mem_done) state_next = is_store(op) ? retire_state : ST_WB;
      ST_PAUSE:  if (!dbg_en || dbg_step) state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_FETCH;
    endcase
  end

  // Everything is held low while rst is asserted, independent of state.
  always_comb begin
    pc_ld      = 1'b0;
    pc_sel     = PCSEL_INC;
    ir_ld      = 1'b0;
    mdr_ld     = 1'b0;
    rf_we      = 1'b0;
    rf_wsel    = WSEL_ALU;
    rf_r7      = 1'b0;
    alu_op     = ALU_ADD;
    cc_ld      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_asel   = ASEL_PC;
    instr_done = 1'b0;
    paused     = 1'b0;
    halted     = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_FETCH: begin
          mem_req  = 1'b1;
          mem_asel = ASEL_PC;
          if (mem_done) begin
            ir_ld  = 1'b1;
            pc_ld  = 1'b1;
            pc_sel = PCSEL_INC;
          end
        end
        ST_EXEC: begin
          instr_done = 1'b1;
          case (op)
            OP_ADD, OP_AND, OP_NOT: begin
              rf_we   = 1'b1;
              rf_wsel = WSEL_ALU;
              cc_ld   = 1'b1;
              alu_op  = (op == OP_ADD) ? ALU_ADD : (op == OP_AND) ? ALU_AND : ALU_NOT;
            end
            OP_LEA: begin
              rf_we   = 1'b1;
              rf_wsel = WSEL_EA;
            end
            OP_BR: begin
              if (|(ir[11:9] & nzp)) begin
                pc_ld  = 1'b1;
                pc_sel = PCSEL_OFF9;
              end
            end
            OP_JMP: begin
              pc_ld  = 1'b1;
              pc_sel = PCSEL_BASER;
            end
            OP_JSR: begin
              rf_we   = 1'b1;
              rf_wsel = WSEL_PC;
              rf_r7   = 1'b1;
              pc_ld   = 1'b1;
              pc_sel  = ir[11] ? PCSEL_OFF11 : PCSEL_BASER;
            end
            default: ;
          endcase
        end
        ST_IND: begin
          mem_req  = 1'b1;
          mem_asel = ASEL_EA;
          mdr_ld   = mem_done;
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          mem_asel = (op == OP_LDI || op == OP_STI) ? ASEL_MDR : ASEL_EA;
          mem_we   = is_store(op);
          if (mem_done) begin
            if (is_store(op)) instr_done = 1'b1;
            else              mdr_ld     = 1'b1;
          end
        end
        ST_WB: begin
          rf_we      = 1'b1;
          rf_wsel    = WSEL_MDR;
          cc_ld      = 1'b1;
          instr_done = 1'b1;
        end
        ST_PAUSE: paused = (DBG_SUPPORT != 0);
        ST_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_mc_control.sv
// Bench for punc_mc_control: a ready-handshake instance and a fixed-latency
// (3 cycle) instance, checked cycle by cycle against a trace-level model.
module tb_punc_mc_control;

  typedef struct packed {
    logic       pc_ld;
    logic [1:0] pc_sel;
    logic       ir_ld;
    logic       mdr_ld;
    logic       rf_we;
    logic [1:0] rf_wsel;
    logic       rf_r7;
    logic [1:0] alu_op;
    logic       cc_ld;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_asel;
    logic       instr_done;
    logic       paused;
    logic       halted;
    logic       illegal;
  } vec_t;

  logic        clk = 1'b0;
  logic [1:0]  rst_v = 2'b11;
  logic [15:0] ir = '0;
  logic [2:0]  nzp = '0;
  logic        mem_ready = 1'b0;
  logic        dbg_en = 1'b0;
  logic        dbg_step = 1'b0;

  vec_t got_v [2];
  vec_t exp_v [2];
  bit   chk_en = 1'b0;
  int   act = 0;
  int   ncyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_req [2] = '{0, 0};
  int   n_mdr [2] = '{0, 0};
  int   n_done [2] = '{0, 0};

  always #5 clk = ~clk;

  // Instance 0 waits on mem_ready; instance 1 uses a fixed 3-cycle access.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic       pc_ld, ir_ld, mdr_ld, rf_we, rf_r7, cc_ld, mem_req, mem_we;
    logic       instr_done, paused, halted, illegal;
    logic [1:0] pc_sel, rf_wsel, alu_op, mem_asel;

    punc_mc_control #(
      .USE_MEM_READY(gi == 0 ? 1 : 0),
      .MEM_LATENCY  (3),
      .DBG_SUPPORT  (1)
    ) dut (
      .clk(clk), .rst(rst_v[gi]), .ir(ir), .nzp(nzp), .mem_ready(mem_ready),
      .dbg_en(dbg_en), .dbg_step(dbg_step), .pc_ld(pc_ld), .pc_sel(pc_sel),
      .ir_ld(ir_ld), .mdr_ld(mdr_ld), .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_r7(rf_r7),
      .alu_op(alu_op), .cc_ld(cc_ld), .mem_req(mem_req), .mem_we(mem_we),
      .mem_asel(mem_asel), .instr_done(instr_done), .paused(paused),
      .halted(halted), .illegal(illegal)
    );

    assign got_v[gi] = {pc_ld, pc_sel, ir_ld, mdr_ld, rf_we, rf_wsel, rf_r7, alu_op,
                        cc_ld, mem_req, mem_we, mem_asel, instr_done, paused, halted, illegal};
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (got_v[d] !== exp_v[d]) begin
          errors++;
          $display("FAIL cycle dut%0d t=%0t got=%h exp=%h", d, $time, got_v[d], exp_v[d]);
        end
        if (got_v[d].mem_req)    n_req[d]++;
        if (got_v[d].mdr_ld)     n_mdr[d]++;
        if (got_v[d].instr_done) n_done[d]++;
      end
    end
  end

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step(input vec_t e, input logic rdy);
    mem_ready = rdy;
    exp_v[act] = e;
    exp_v[1 - act] = '0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  // kind 0: instruction fetch, 1: data/pointer read, 2: store that retires
  task automatic access(input int k, input logic [1:0] asel, input logic we, input int kind);
    vec_t v;
    for (int c = 0; c < k; c++) begin
      v = '0;
      v.mem_req  = 1'b1;
      v.mem_asel = asel;
      v.mem_we   = we;
      if (c == k - 1) begin
        if (kind == 0) begin v.ir_ld = 1'b1; v.pc_ld = 1'b1; end
        else if (kind == 1) v.mdr_ld = 1'b1;
        else v.instr_done = 1'b1;
      end
      step(v, c == k - 1);
    end
  endtask

  task automatic wb();
    vec_t v;
    v = '0; v.rf_we = 1'b1; v.rf_wsel = 2'd1; v.cc_ld = 1'b1; v.instr_done = 1'b1;
    step(v, 1'b0);
  endtask

  // One non-halting instruction from FETCH to retire; k is the access length.
  task automatic play(input logic [15:0] instr, input logic [2:0] cc, input int k);
    vec_t v;
    int ck;
    logic [3:0] op;
    ck = (act == 1) ? 3 : k;
    ir = instr; nzp = cc; op = instr[15:12]; ncyc = 0;
    access(ck, 2'd0, 1'b0, 0);
    step('0, 1'b0);
    v = '0;
    v.instr_done = 1'b1;
    case (op)
      4'h1, 4'h5, 4'h9: begin
        v.rf_we = 1'b1; v.cc_ld = 1'b1;
        v.alu_op = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd2;
        step(v, 1'b0);
      end
      4'hE: begin v.rf_we = 1'b1; v.rf_wsel = 2'd2; step(v, 1'b0); end
      4'h0: begin
        if ((instr[11] & cc[2]) | (instr[10] & cc[1]) | (instr[9] & cc[0])) begin
          v.pc_ld = 1'b1; v.pc_sel = 2'd1;
        end
        step(v, 1'b0);
      end
      4'hC: begin v.pc_ld = 1'b1; v.pc_sel = 2'd2; step(v, 1'b0); end
      4'h4: begin
        v.rf_we = 1'b1; v.rf_wsel = 2'd3; v.rf_r7 = 1'b1; v.pc_ld = 1'b1;
        v.pc_sel = instr[11] ? 2'd3 : 2'd2;
        step(v, 1'b0);
      end
      4'h2, 4'h6: begin access(ck, 2'd1, 1'b0, 1); wb(); end
      4'h3, 4'h7: access(ck, 2'd1, 1'b1, 2);
      4'hA: begin access(ck, 2'd1, 1'b0, 1); access(ck, 2'd2, 1'b0, 1); wb(); end
      4'hB: begin access(ck, 2'd1, 1'b0, 1); access(ck, 2'd2, 1'b1, 2); end
      default: ;
    endcase
    $display("dut%0d instr=%h nzp=%b cycles=%0d", act, instr, cc, ncyc);
  endtask

  task automatic restart(input int d);
    rst_v = 2'b11;
    step('0, 1'b0);
    step('0, 1'b0);
    act = d;
    rst_v[d] = 1'b0;
  endtask

  initial begin
    vec_t v;
    int r0, m0, d0;
    @(posedge clk); #1;
    step('0, 1'b0);
    step('0, 1'b0);

    // Reset during a pending fetch, then a clean fetch afterwards.
    for (int d = 0; d < 2; d++) begin
      restart(d);
      v = '0; v.mem_req = 1'b1;
      step(v, 1'b0);
      step(v, 1'b0);
      rst_v[d] = 1'b1;
      step('0, 1'b0);
      rst_v[d] = 1'b0;
      r0 = n_req[d];
      play(16'h1261, 3'b001, 2);
      lit("fetch_after_rst_req", n_req[d] - r0, (d == 1) ? 3 : 2);
    end

    // Fixed latency 3: full instruction mix back to back.
    restart(1);
    r0 = n_req[1]; d0 = n_done[1];
    play(16'h1261, 3'b001, 3);
    lit("add_L3_cycles", ncyc, 5);
    lit("add_L3_req", n_req[1] - r0, 3);
    lit("add_L3_done", n_done[1] - d0, 1);
    play(16'h5262, 3'b010, 3);
    play(16'h967F, 3'b100, 3);
    play(16'hE5FF, 3'b001, 3);
    play(16'h0405, 3'b100, 3);
    play(16'h0405, 3'b010, 3);
    play(16'hC1C0, 3'b010, 3);
    play(16'h4801, 3'b010, 3);
    play(16'h4080, 3'b010, 3);
    play(16'h2401, 3'b010, 3);
    lit("ld_L3_cycles", ncyc, 8);
    play(16'h6401, 3'b010, 3);
    play(16'h3401, 3'b010, 3);
    lit("st_L3_cycles", ncyc, 7);
    play(16'h7401, 3'b010, 3);
    play(16'hA402, 3'b010, 3);
    lit("ldi_L3_cycles", ncyc, 11);
    play(16'hB402, 3'b010, 3);
    lit("sti_L3_cycles", ncyc, 10);

    // Ready handshake with varying wait lengths.
    restart(0);
    m0 = n_mdr[0]; r0 = n_req[0];
    play(16'hA402, 3'b001, 2);
    lit("ldi_rdy2_cycles", ncyc, 8);
    lit("ldi_rdy2_mdr", n_mdr[0] - m0, 2);
    lit("ldi_rdy2_req", n_req[0] - r0, 6);
    play(16'h2401, 3'b001, 1);
    lit("ld_rdy1_cycles", ncyc, 4);
    play(16'hB402, 3'b001, 4);
    lit("sti_rdy4_cycles", ncyc, 13);
    play(16'h0E05, 3'b001, 1);
    lit("br_rdy1_cycles", ncyc, 3);

    // Single-step debug.
    restart(0);
    dbg_en = 1'b1;
    play(16'h1261, 3'b001, 1);
    r0 = n_req[0];
    v = '0; v.paused = 1'b1;
    for (int i = 0; i < 4; i++) step(v, 1'b1);
    lit("pause_no_req", n_req[0] - r0, 0);
    dbg_step = 1'b1;
    step(v, 1'b0);
    dbg_step = 1'b0;
    d0 = n_done[0];
    play(16'h1261, 3'b001, 1);
    step(v, 1'b0);
    step(v, 1'b0);
    lit("step_one_instr", n_done[0] - d0, 1);
    dbg_en = 1'b0;
    step(v, 1'b0);
    play(16'h5262, 3'b001, 2);

    // Illegal opcode halt, then TRAP halt.
    restart(0);
    ir = 16'hD000; ncyc = 0;
    access(2, 2'd0, 1'b0, 0);
    step('0, 1'b0);
    dbg_en = 1'b1;
    v = '0; v.halted = 1'b1; v.illegal = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dbg_step = i[0];
      step(v, 1'b0);
    end
    dbg_step = 1'b0; dbg_en = 1'b0;
    $display("dut0 instr=d000 halted illegal");
    rst_v[0] = 1'b1;
    step('0, 1'b0);
    rst_v[0] = 1'b0;
    ir = 16'hF025;
    access(2, 2'd0, 1'b0, 0);
    step('0, 1'b0);
    v = '0; v.halted = 1'b1;
    for (int i = 0; i < 5; i++) step(v, 1'b1);
    $display("dut0 instr=f025 halted");

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
